// File: rtl/sr_flag_register.sv
// sr_flag_register
//
// Purpose:
//   A bank of WIDTH clocked set/reset flag cells. It is the synchronous replacement for a
//   cross-coupled NAND SR latch. For each channel the block:
//     - deglitches the raw set and clear requests,
//     - applies the requests to the stored flag while en is high,
//     - resolves a simultaneous set and clear according to CONFLICT_MODE,
//     - pulses changed for one cycle after the flag value moves,
//     - latches a sticky conflict flag.
//   Channels are fully independent of one another.
//
// Parameters:
//   WIDTH         number of channels
//   FILTER        number of edges a raw input must differ from its filtered value before the
//                 new value is accepted; 0 bypasses the filter (combinational pass-through)
//   CONFLICT_MODE action when filtered set and clear are both 1:
//                 0 hold, 1 set, 2 clear, 3 toggle; any other value behaves as hold
//   RESET_VAL     value loaded into q while rst is high
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active high
//   en            update enable for q and conflict; the filters run regardless of en
//   set_in        raw per-channel set requests
//   clr_in        raw per-channel clear requests
//   conflict_clr  per-channel clear of the sticky conflict flag
//   q             stored flag values
//   q_n           exact complement of q
//   changed       one-cycle pulse on channels whose q changed on the previous edge
//   conflict      sticky: filtered set and clear were both 1 on an enabled edge

module sr_flag_register #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      FILTER        = 2,
    parameter int unsigned      CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] set_in,
    input  logic [WIDTH-1:0] clr_in,
    input  logic [WIDTH-1:0] conflict_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] conflict
);

    typedef enum logic [1:0] {
        ModeHold   = 2'd0,
        ModeSet    = 2'd1,
        ModeClr    = 2'd2,
        ModeToggle = 2'd3
    } mode_e;

    // Out-of-range modes fold onto hold so the datapath is always well defined.
    localparam mode_e CONFLICT_ACTION =
        (CONFLICT_MODE > 3) ? ModeHold : mode_e'(2'(CONFLICT_MODE));

    if (CONFLICT_MODE > 3) begin : g_bad_mode
        $error("sr_flag_register: CONFLICT_MODE %0d is illegal, behaving as hold",
               CONFLICT_MODE);
    end

    if (WIDTH == 0) begin : g_bad_width
        $error("sr_flag_register: WIDTH must be at least 1");
    end

    // ------------------------------------------------------------------
    // Input filters
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] set_f;
    logic [WIDTH-1:0] clr_f;

    if (FILTER == 0) begin : g_bypass

        assign set_f = set_in;
        assign clr_f = clr_in;

    end else begin : g_filter

        // The counter only has to reach FILTER-1, so this width never overflows.
        localparam int unsigned CNT_W = $clog2(FILTER + 1);
        localparam int unsigned NBITS = 2 * WIDTH;

        logic [NBITS-1:0]            raw;
        logic [NBITS-1:0]            filt_q;
        logic [NBITS-1:0]            filt_d;
        logic [NBITS-1:0][CNT_W-1:0] cnt_q;
        logic [NBITS-1:0][CNT_W-1:0] cnt_d;

        // Set and clear share one filter array: low half is set, high half is clear.
        assign raw = {clr_in, set_in};

        always_comb begin
            filt_d = filt_q;
            cnt_d  = '0;
            for (int i = 0; i < NBITS; i++) begin
                if (raw[i] != filt_q[i]) begin
                    if (cnt_q[i] == CNT_W'(FILTER - 1)) begin
                        // Held long enough: accept it and restart from zero.
                        filt_d[i] = raw[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                // raw == filtered leaves cnt_d at zero, so short pulses are discarded.
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                filt_q <= '0;
                cnt_q  <= '0;
            end else begin
                filt_q <= filt_d;
                cnt_q  <= cnt_d;
            end
        end

        assign set_f = filt_q[WIDTH-1:0];
        assign clr_f = filt_q[NBITS-1:WIDTH];

    end

    // ------------------------------------------------------------------
    // Flag core
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] changed_q;
    logic [WIDTH-1:0] changed_d;
    logic [WIDTH-1:0] conflict_q;
    logic [WIDTH-1:0] conflict_d;

    always_comb begin
        q_d        = q_q;
        // A new conflict is applied after the clear, so it wins on the same edge.
        conflict_d = conflict_q & ~conflict_clr;
        for (int i = 0; i < WIDTH; i++) begin
            if (en) begin
                unique case ({set_f[i], clr_f[i]})
                    2'b00: q_d[i] = q_q[i];
                    2'b10: q_d[i] = 1'b1;
                    2'b01: q_d[i] = 1'b0;
                    2'b11: begin
                        conflict_d[i] = 1'b1;
                        unique case (CONFLICT_ACTION)
                            ModeHold:   q_d[i] = q_q[i];
                            ModeSet:    q_d[i] = 1'b1;
                            ModeClr:    q_d[i] = 1'b0;
                            ModeToggle: q_d[i] = ~q_q[i];
                        endcase
                    end
                endcase
            end
        end
        changed_d = q_d ^ q_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= RESET_VAL;
            changed_q  <= '0;
            conflict_q <= '0;
        end else begin
            q_q        <= q_d;
            changed_q  <= changed_d;
            conflict_q <= conflict_d;
        end
    end

    assign q        = q_q;
    assign q_n      = ~q_q;
    assign changed  = changed_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_flag_register.sv
module tb_sr_flag_register;

    localparam int KindQ   = 0;
    localparam int KindQn  = 1;
    localparam int KindChg = 2;
    localparam int KindCfl = 3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] set_in;
    logic [7:0] clr_in;
    logic [7:0] conflict_clr;

    // Instances: 0 F2/hold/A5, 1 F0/hold, 2 F2/set, 3 F2/clear, 4 F2/toggle.
    logic [4:0][7:0] q_all;
    logic [4:0][7:0] qn_all;
    logic [4:0][7:0] chg_all;
    logic [4:0][7:0] cfl_all;

    sr_flag_register #(.WIDTH(8), .FILTER(2), .CONFLICT_MODE(0), .RESET_VAL(8'hA5)) u_main (
        .clk(clk), .rst(rst), .en(en), .set_in(set_in), .clr_in(clr_in),
        .conflict_clr(conflict_clr), .q(q_all[0]), .q_n(qn_all[0]),
        .changed(chg_all[0]), .conflict(cfl_all[0])
    );
    sr_flag_register #(.WIDTH(8), .FILTER(0), .CONFLICT_MODE(0), .RESET_VAL(8'h00)) u_f0 (
        .clk(clk), .rst(rst), .en(en), .set_in(set_in), .clr_in(clr_in),
        .conflict_clr(conflict_clr), .q(q_all[1]), .q_n(qn_all[1]),
        .changed(chg_all[1]), .conflict(cfl_all[1])
    );
    sr_flag_register #(.WIDTH(8), .FILTER(2), .CONFLICT_MODE(1), .RESET_VAL(8'h00)) u_m1 (
        .clk(clk), .rst(rst), .en(en), .set_in(set_in), .clr_in(clr_in),
        .conflict_clr(conflict_clr), .q(q_all[2]), .q_n(qn_all[2]),
        .changed(chg_all[2]), .conflict(cfl_all[2])
    );
    sr_flag_register #(.WIDTH(8), .FILTER(2), .CONFLICT_MODE(2), .RESET_VAL(8'h00)) u_m2 (
        .clk(clk), .rst(rst), .en(en), .set_in(set_in), .clr_in(clr_in),
        .conflict_clr(conflict_clr), .q(q_all[3]), .q_n(qn_all[3]),
        .changed(chg_all[3]), .conflict(cfl_all[3])
    );
    sr_flag_register #(.WIDTH(8), .FILTER(2), .CONFLICT_MODE(3), .RESET_VAL(8'h00)) u_m3 (
        .clk(clk), .rst(rst), .en(en), .set_in(set_in), .clr_in(clr_in),
        .conflict_clr(conflict_clr), .q(q_all[4]), .q_n(qn_all[4]),
        .changed(chg_all[4]), .conflict(cfl_all[4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         inst;
        int         kind;
        logic [7:0] mask;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] act;

    function automatic logic [7:0] pick(input int inst, input int kind);
        case (kind)
            KindQ:   return q_all[inst];
            KindQn:  return qn_all[inst];
            KindChg: return chg_all[inst];
            default: return cfl_all[inst];
        endcase
    endfunction

    // Expected response for the cycle that is currently open.
    task automatic chk(input int inst, input int kind, input logic [7:0] mask,
                       input logic [7:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.inst = inst;
        e.kind = kind;
        e.mask = mask;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: mid-cycle, pop every expectation due now and compare.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur    = sb.pop_front();
            act    = pick(cur.inst, cur.kind);
            checks = checks + 1;
            if ((act & cur.mask) !== (cur.exp & cur.mask) || cur.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL %s: inst %0d got %h required %h (mask %h) at cycle %0d",
                         cur.name, cur.inst, act & cur.mask, cur.exp & cur.mask,
                         cur.mask, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        set_in       = 8'h00;
        clr_in       = 8'h00;
        conflict_clr = 8'h00;
        tick();
        tick();
        chk(0, KindQ,   8'hFF, 8'hA5, "rst_q");
        chk(0, KindQn,  8'hFF, 8'h5A, "rst_qn");
        chk(0, KindChg, 8'hFF, 8'h00, "rst_changed");
        chk(0, KindCfl, 8'hFF, 8'h00, "rst_conflict");
        chk(2, KindQ,   8'hFF, 8'h00, "rst_q_m1");
        rst = 1'b0;
        tick();

        // Latency: raw set on channel 0 reaches q on the third edge.
        set_in = 8'h01;
        en     = 1'b1;
        tick();
        chk(2, KindQ,   8'h01, 8'h00, "lat_e1_q");
        tick();
        chk(2, KindQ,   8'h01, 8'h00, "lat_e2_q");
        chk(2, KindChg, 8'h01, 8'h00, "lat_e2_chg");
        tick();
        chk(2, KindQ,   8'h01, 8'h01, "lat_e3_q");
        chk(2, KindChg, 8'h01, 8'h01, "lat_e3_chg");
        tick();
        chk(2, KindQ,   8'h01, 8'h01, "lat_e4_q");
        chk(2, KindChg, 8'h01, 8'h00, "lat_e4_chg");

        // One-cycle glitch on set_in[3].
        set_in = 8'h08;
        tick();
        chk(1, KindQ,   8'h08, 8'h08, "f0_glitch_q");
        chk(1, KindChg, 8'h08, 8'h08, "f0_glitch_chg");
        chk(2, KindQ,   8'h08, 8'h00, "f2_glitch_q_e1");
        set_in = 8'h00;
        repeat (3) tick();
        chk(2, KindQ,   8'h08, 8'h00, "f2_glitch_q");
        chk(2, KindChg, 8'h08, 8'h00, "f2_glitch_chg");
        chk(0, KindQ,   8'h08, 8'h00, "f2_glitch_q_main");

        // Clear channel 0 everywhere, then let the filters settle.
        clr_in = 8'h01;
        repeat (4) tick();
        clr_in = 8'h00;
        repeat (3) tick();
        chk(0, KindQ, 8'h01, 8'h00, "pre_cfl_q0");
        chk(4, KindQ, 8'h01, 8'h00, "pre_cfl_q4");

        // Persistent conflict on channel 0.
        set_in = 8'h01;
        clr_in = 8'h01;
        tick();
        tick();
        chk(0, KindCfl, 8'h01, 8'h00, "cfl_not_yet");
        tick();
        chk(0, KindQ,   8'h01, 8'h00, "mode0_hold");
        chk(2, KindQ,   8'h01, 8'h01, "mode1_set");
        chk(3, KindQ,   8'h01, 8'h00, "mode2_clr");
        chk(4, KindQ,   8'h01, 8'h01, "mode3_t1");
        chk(0, KindCfl, 8'h01, 8'h01, "mode0_cfl");
        chk(2, KindCfl, 8'h01, 8'h01, "mode1_cfl");
        chk(3, KindCfl, 8'h01, 8'h01, "mode2_cfl");
        chk(4, KindCfl, 8'h01, 8'h01, "mode3_cfl");
        tick();
        chk(4, KindQ,   8'h01, 8'h00, "mode3_t2");
        chk(4, KindChg, 8'h01, 8'h01, "mode3_chg2");
        chk(2, KindChg, 8'h01, 8'h00, "mode1_stable");
        tick();
        chk(4, KindQ,   8'h01, 8'h01, "mode3_t3");
        chk(4, KindChg, 8'h01, 8'h01, "mode3_chg3");

        // Sticky conflict on channel 2, cleared once the conflict is gone.
        set_in = 8'h05;
        clr_in = 8'h05;
        repeat (3) tick();
        chk(0, KindCfl, 8'h04, 8'h04, "cfl2_set");
        chk(0, KindQ,   8'h04, 8'h04, "cfl2_hold_q");
        set_in = 8'h01;
        clr_in = 8'h01;
        repeat (3) tick();
        chk(0, KindCfl, 8'h04, 8'h04, "cfl2_sticky");
        conflict_clr = 8'h04;
        tick();
        chk(0, KindCfl, 8'h04, 8'h00, "cfl2_cleared");
        chk(0, KindCfl, 8'h01, 8'h01, "cfl0_kept");
        conflict_clr = 8'h00;

        // Clear while the conflict is still present: set wins.
        set_in = 8'h05;
        clr_in = 8'h05;
        repeat (3) tick();
        chk(0, KindCfl, 8'h04, 8'h04, "cfl2_reset_again");
        conflict_clr = 8'h04;
        tick();
        chk(0, KindCfl, 8'h04, 8'h04, "cfl2_set_wins");
        conflict_clr = 8'h00;

        // Mid-run asynchronous reset, checked before any further clock edge.
        chk(0, KindQ,   8'hFF, 8'hA4, "prerst_q");
        chk(0, KindCfl, 8'hFF, 8'h05, "prerst_cfl");
        tick();
        rst    = 1'b1;
        set_in = 8'h00;
        clr_in = 8'h00;
        #1;
        chk(0, KindQ,   8'hFF, 8'hA5, "async_rst_q");
        chk(0, KindQn,  8'hFF, 8'h5A, "async_rst_qn");
        chk(0, KindChg, 8'hFF, 8'h00, "async_rst_chg");
        chk(0, KindCfl, 8'hFF, 8'h00, "async_rst_cfl");
        tick();
        rst = 1'b0;

        // Enable gating.
        en     = 1'b0;
        set_in = 8'hFF;
        repeat (10) tick();
        chk(0, KindQ,   8'hFF, 8'hA5, "en0_hold_main");
        chk(0, KindCfl, 8'hFF, 8'h00, "en0_cfl");
        chk(2, KindQ,   8'hFF, 8'h00, "en0_hold_m1");
        en = 1'b1;
        tick();
        chk(0, KindQ,   8'hFF, 8'hFF, "en1_q_main");
        chk(0, KindQn,  8'hFF, 8'h00, "en1_qn_main");
        chk(0, KindChg, 8'hFF, 8'h5A, "en1_chg_main");
        chk(2, KindQ,   8'hFF, 8'hFF, "en1_q_m1");
        chk(2, KindChg, 8'hFF, 8'hFF, "en1_chg_m1");
        tick();
        chk(2, KindChg, 8'hFF, 8'h00, "en1_chg_end");
        set_in = 8'h00;

        for (int i = 0; i < 5 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
            errors = errors + sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
